// File: rtl/arb_pkg.sv
// Shared definitions for the data-memory bus arbiter.
//   arb_state_t : FSM state, which is the owner of the previous cycle
//   owner_t     : combinational bus owner for the current cycle
//   MAX_WAIT_DEF: default number of refusals before a DMA request is forced in
//   WAIT_W      : width of the DMA wait counter (MAX_WAIT is limited to 1..15)
package arb_pkg;

   localparam int MAX_WAIT_DEF = 4;
   localparam int WAIT_W       = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CPU  = 2'd1,
      ST_DMA  = 2'd2
   } arb_state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_DMA  = 2'd2
   } owner_t;

   function automatic arb_state_t owner_to_state(input owner_t own);
      arb_state_t st;
      case (own)
         OWN_CPU: st = ST_CPU;
         OWN_DMA: st = ST_DMA;
         default: st = ST_IDLE;
      endcase
      return st;
   endfunction

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating up-counter with synchronous clear.
// Used as the DMA starvation counter and as the optional performance counters.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   clr        : synchronous clear (wins over inc)
//   inc        : count up by one unless already at MAX
//   count      : current value
//   sat        : count == MAX
module arb_wait_counter
   import arb_pkg::*;
#(
   parameter int           W   = WAIT_W,
   parameter logic [W-1:0] MAX = '1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count,
   output logic         sat
);

   assign sat = (count == MAX);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         count <= '0;
      end else if (inc && !sat) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/dmem_bus_arbiter.sv
// Arbiter sharing the data-memory/peripheral bus between the CPU MEM stage and
// a secondary DMA master. One owner per cycle; the CPU normally wins, but a
// DMA request refused MAX_WAIT times in a row is forced onto the bus.
// Optional build macro ARB_PERF_CNT_EN adds saturating perf counters.
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   cpu_rd/wr/addr/wdata          : MEM-stage access request
//   cpu_rdata, cpu_stall          : load data (zero latency) and pipeline stall
//   dma_req/we/addr/wdata         : DMA request, held until dma_gnt
//   dma_gnt                       : DMA owns the bus this cycle (combinational)
//   dma_rdata, dma_rvalid         : registered DMA read data and its pulse
//   bus_addr/rd/wr/wdata/rdata    : bus side
//   perf_stall_cnt/perf_force_cnt : (ARB_PERF_CNT_EN) CPU stall cycles, forced grants
//   state                         : debug view of the FSM (previous-cycle owner)
// Handshake: dma_req is a request held high until the cycle dma_gnt is seen
// high; that cycle is the transfer. A read returns data on dma_rdata with
// dma_rvalid high in the following cycle. The CPU side has no handshake:
// cpu_stall high means the access did not happen and is presented again.
module dmem_bus_arbiter
   import arb_pkg::*;
#(
   parameter int MAX_WAIT = MAX_WAIT_DEF,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_rd,
   input  logic              cpu_wr,
   input  logic [31:0]       cpu_addr,
   input  logic [31:0]       cpu_wdata,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_stall,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [31:0]       dma_addr,
   input  logic [31:0]       dma_wdata,
   output logic              dma_gnt,
   output logic [31:0]       dma_rdata,
   output logic              dma_rvalid,
   output logic [31:0]       bus_addr,
   output logic              bus_rd,
   output logic              bus_wr,
   output logic [31:0]       bus_wdata,
   input  logic [31:0]       bus_rdata,
`ifdef ARB_PERF_CNT_EN
   output logic [CNT_W-1:0]  perf_stall_cnt,
   output logic [CNT_W-1:0]  perf_force_cnt,
`endif
   output arb_state_t        state
);

   logic              cpu_req;
   logic              force_dma;
   owner_t            owner;
   logic [WAIT_W-1:0] wait_cnt;
   logic              wait_sat;

   assign cpu_req   = cpu_rd | cpu_wr;
   assign force_dma = dma_req & wait_sat;

   // Reset forces NONE so nothing is written and nobody is stalled or granted.
   always_comb begin
      owner = OWN_NONE;
      if (reset)          owner = OWN_NONE;
      else if (force_dma) owner = OWN_DMA;
      else if (cpu_req)   owner = OWN_CPU;
      else if (dma_req)   owner = OWN_DMA;
   end

   assign dma_gnt   = (owner == OWN_DMA);
   assign cpu_stall = !reset && cpu_req && (owner != OWN_CPU);

   always_comb begin
      bus_rd    = 1'b0;
      bus_wr    = 1'b0;
      bus_addr  = '0;
      bus_wdata = '0;
      cpu_rdata = '0;
      case (owner)
         OWN_CPU: begin
            // rd and wr together pass straight through: the bus returns the
            // old word while the new one commits at the edge.
            bus_rd    = cpu_rd;
            bus_wr    = cpu_wr;
            bus_addr  = cpu_addr;
            bus_wdata = cpu_wdata;
            cpu_rdata = bus_rdata;
         end
         OWN_DMA: begin
            bus_rd    = !dma_we;
            bus_wr    = dma_we;
            bus_addr  = dma_addr;
            bus_wdata = dma_wdata;
         end
         default: ;
      endcase
   end

   // Starvation counter: counts consecutive refused cycles of a pending DMA.
   // Clearing on the grant is what lets the CPU win the cycle after a force.
   arb_wait_counter #(
      .W   (WAIT_W),
      .MAX (WAIT_W'(MAX_WAIT))
   ) u_wait (
      .clk   (clk),
      .reset (reset),
      .clr   (!dma_req || dma_gnt),
      .inc   (dma_req && !dma_gnt),
      .count (wait_cnt),
      .sat   (wait_sat)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         dma_rvalid <= 1'b0;
         dma_rdata  <= '0;
      end else begin
         state      <= owner_to_state(owner);
         dma_rvalid <= dma_gnt && !dma_we;
         if (dma_gnt && !dma_we) dma_rdata <= bus_rdata;
      end
   end

`ifdef ARB_PERF_CNT_EN
   logic stall_sat_unused;
   logic force_sat_unused;

   arb_wait_counter #(.W(CNT_W)) u_perf_stall (
      .clk   (clk),
      .reset (reset),
      .clr   (1'b0),
      .inc   (cpu_stall),
      .count (perf_stall_cnt),
      .sat   (stall_sat_unused)
   );

   arb_wait_counter #(.W(CNT_W)) u_perf_force (
      .clk   (clk),
      .reset (reset),
      .clr   (1'b0),
      .inc   (force_dma),
      .count (perf_force_cnt),
      .sat   (force_sat_unused)
   );
`endif

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Bench for dmem_bus_arbiter: directed vector table, hand-written corner
// sequences and random traffic, all checked against a cycle model of the
// arbitration rules and a model memory.
module tb_dmem_bus_arbiter;

   localparam int MAX_WAIT = 4;
   localparam int CNT_W    = 16;

   logic        clk = 1'b0;
   logic        reset, cpu_rd, cpu_wr, dma_req, dma_we;
   logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
   logic [31:0] cpu_rdata, dma_rdata, bus_addr, bus_wdata, bus_rdata;
   logic        cpu_stall, dma_gnt, dma_rvalid, bus_rd, bus_wr;
   logic [1:0]  dbg_state;
`ifdef ARB_PERF_CNT_EN
   logic [CNT_W-1:0] perf_stall_cnt, perf_force_cnt;
`endif

   always #5 clk = ~clk;

   dmem_bus_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .cpu_rd     (cpu_rd),
      .cpu_wr     (cpu_wr),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cpu_stall  (cpu_stall),
      .dma_req    (dma_req),
      .dma_we     (dma_we),
      .dma_addr   (dma_addr),
      .dma_wdata  (dma_wdata),
      .dma_gnt    (dma_gnt),
      .dma_rdata  (dma_rdata),
      .dma_rvalid (dma_rvalid),
      .bus_addr   (bus_addr),
      .bus_rd     (bus_rd),
      .bus_wr     (bus_wr),
      .bus_wdata  (bus_wdata),
      .bus_rdata  (bus_rdata),
`ifdef ARB_PERF_CNT_EN
      .perf_stall_cnt (perf_stall_cnt),
      .perf_force_cnt (perf_force_cnt),
`endif
      .state      (dbg_state)
   );

   // Bus-side memory: combinational read, write committed at the clock edge.
   logic [31:0] mem   [256];
   assign bus_rdata = mem[bus_addr[9:2]];

   // Reference model state
   logic [31:0] m_mem [256];
   int          m_wait, m_prev, m_stall_cnt, m_force_cnt;
   logic        m_rvalid;
   logic [31:0] m_rdata;

   int n_vec = 0;
   int n_bad = 0;

   // Values sampled by apply() for the table checks
   logic s_gnt, s_stall, s_rd, s_wr, s_rvalid;
   logic [31:0] s_cpu_rdata;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive one cycle, check every output against the model, then advance.
   task automatic apply(input logic rst, input logic c_rd, input logic c_wr,
                        input logic [31:0] c_addr, input logic [31:0] c_wdata,
                        input logic d_req, input logic d_we,
                        input logic [31:0] d_addr, input logic [31:0] d_wdata);
      int          own, idx;
      logic        creq, e_rd, e_wr, forced, sb_wr;
      logic [31:0] e_addr, e_wdata, e_rdata, sb_addr, sb_wdata;
      reset = rst; cpu_rd = c_rd; cpu_wr = c_wr; cpu_addr = c_addr; cpu_wdata = c_wdata;
      dma_req = d_req; dma_we = d_we; dma_addr = d_addr; dma_wdata = d_wdata;
      creq   = c_rd | c_wr;
      forced = !rst && d_req && (m_wait == MAX_WAIT);
      if (rst)         own = 0;
      else if (forced) own = 2;
      else if (creq)   own = 1;
      else if (d_req)  own = 2;
      else             own = 0;
      e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_wdata = '0;
      if (own == 1) begin
         e_rd = c_rd; e_wr = c_wr; e_addr = c_addr; e_wdata = c_wdata;
      end else if (own == 2) begin
         e_rd = !d_we; e_wr = d_we; e_addr = d_addr; e_wdata = d_wdata;
      end
      idx     = int'(e_addr[9:2]);
      e_rdata = m_mem[idx];

      @(negedge clk);
      s_gnt = dma_gnt; s_stall = cpu_stall; s_rd = bus_rd; s_wr = bus_wr;
      s_rvalid = dma_rvalid; s_cpu_rdata = cpu_rdata;
      chk("dma_gnt",    32'(dma_gnt),   32'(own == 2));
      chk("cpu_stall",  32'(cpu_stall), 32'(!rst && creq && own != 1));
      chk("bus_rd",     32'(bus_rd),    32'(e_rd));
      chk("bus_wr",     32'(bus_wr),    32'(e_wr));
      chk("bus_addr",   bus_addr,       e_addr);
      chk("bus_wdata",  bus_wdata,      e_wdata);
      chk("cpu_rdata",  cpu_rdata,      (own == 1) ? e_rdata : 32'h0);
      chk("dma_rvalid", 32'(dma_rvalid), 32'(m_rvalid));
      chk("dma_rdata",  dma_rdata,      m_rdata);
      chk("state",      32'(dbg_state), 32'(m_prev));
      sb_wr = bus_wr; sb_addr = bus_addr; sb_wdata = bus_wdata;

      @(posedge clk);
      #1;
      if (sb_wr) mem[sb_addr[9:2]] = sb_wdata;
      if (rst) begin
         m_wait = 0; m_prev = 0; m_rvalid = 1'b0; m_rdata = '0;
         m_stall_cnt = 0; m_force_cnt = 0;
      end else begin
         m_rvalid = (own == 2) && !d_we;
         if (m_rvalid) m_rdata = e_rdata;
         if (!d_req || own == 2)     m_wait = 0;
         else if (m_wait < MAX_WAIT) m_wait++;
         m_prev = own;
         if (creq && own != 1) m_stall_cnt++;
         if (forced) m_force_cnt++;
         if (e_wr) m_mem[idx] = e_wdata;
      end
   endtask

   task automatic idle_cycle();
      apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   typedef struct {
      logic        rst, c_rd, c_wr;
      logic [31:0] c_addr, c_wdata;
      logic        d_req, d_we;
      logic [31:0] d_addr, d_wdata;
      logic        e_gnt, e_stall, e_rd, e_wr, e_rvalid, chk_rdata;
      logic [31:0] e_rdata;
   } vec_t;

   vec_t tbl [14];

   initial begin
      logic [31:0] pre;
      logic        d_pend, d_we_r, rr, crd, cwr;
      logic [31:0] d_addr_r, d_wdata_r;
      int          op;

      for (int i = 0; i < 256; i++) begin
         mem[i]   = $urandom;
         m_mem[i] = mem[i];
      end
      mem[4] = 32'h1234_5678; m_mem[4] = 32'h1234_5678;
      mem[8] = 32'hA5A5_0008; m_mem[8] = 32'hA5A5_0008;

      // Raw reset so the registers are defined before checking starts
      reset = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
      @(posedge clk); #1;
      m_wait = 0; m_prev = 0; m_rvalid = 1'b0; m_rdata = '0;
      m_stall_cnt = 0; m_force_cnt = 0;

      //         rst  rd   wr   c_addr        c_wdata       dreq dwe  d_addr        d_wdata       gnt  stl  brd  bwr  rvl  chk  rdata
      tbl[0]  = '{1'b1,1'b0,1'b1,32'h0000_0040,32'h1111_1111,1'b1,1'b1,32'h0000_0044,32'h2222_2222,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0};
      tbl[1]  = '{1'b0,1'b1,1'b0,32'h4000_0010,32'h0,        1'b0,1'b0,32'h0,        32'h0,        1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,32'h1234_5678};
      tbl[2]  = '{1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b1,1'b1,32'h0000_0010,32'hDEAD_BEEF,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,32'h0};
      tbl[3]  = '{1'b0,1'b1,1'b0,32'h0000_0010,32'h0,        1'b0,1'b0,32'h0,        32'h0,        1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,32'hDEAD_BEEF};
      tbl[4]  = '{1'b0,1'b1,1'b0,32'h0000_0100,32'h0,        1'b1,1'b0,32'h0000_0020,32'h0,        1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h0};
      tbl[5]  = '{1'b0,1'b1,1'b0,32'h0000_0104,32'h0,        1'b1,1'b0,32'h0000_0020,32'h0,        1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h0};
      tbl[6]  = '{1'b0,1'b1,1'b0,32'h0000_0108,32'h0,        1'b1,1'b0,32'h0000_0020,32'h0,        1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h0};
      tbl[7]  = '{1'b0,1'b1,1'b0,32'h0000_010C,32'h0,        1'b1,1'b0,32'h0000_0020,32'h0,        1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h0};
      tbl[8]  = '{1'b0,1'b1,1'b0,32'h0000_0110,32'h0,        1'b1,1'b0,32'h0000_0020,32'h0,        1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,32'h0};
      tbl[9]  = '{1'b0,1'b1,1'b0,32'h0000_0110,32'h0,        1'b0,1'b0,32'h0,        32'h0,        1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,32'h0};
      tbl[10] = '{1'b0,1'b0,1'b1,32'h0000_0020,32'h1111_0000,1'b1,1'b0,32'h0000_0030,32'h0,        1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,32'h0};
      tbl[11] = '{1'b0,1'b0,1'b1,32'h0000_0024,32'h2222_0000,1'b1,1'b0,32'h0000_0030,32'h0,        1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,32'h0};
      tbl[12] = '{1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b1,1'b0,32'h0000_0030,32'h0,        1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,32'h0};
      tbl[13] = '{1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b0,1'b0,32'h0,        32'h0,        1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,32'h0};

      for (int i = 0; i < 14; i++) begin
         apply(tbl[i].rst, tbl[i].c_rd, tbl[i].c_wr, tbl[i].c_addr, tbl[i].c_wdata,
               tbl[i].d_req, tbl[i].d_we, tbl[i].d_addr, tbl[i].d_wdata);
         chk($sformatf("tbl%0d_gnt", i),    32'(s_gnt),    32'(tbl[i].e_gnt));
         chk($sformatf("tbl%0d_stall", i),  32'(s_stall),  32'(tbl[i].e_stall));
         chk($sformatf("tbl%0d_bus_rd", i), 32'(s_rd),     32'(tbl[i].e_rd));
         chk($sformatf("tbl%0d_bus_wr", i), 32'(s_wr),     32'(tbl[i].e_wr));
         chk($sformatf("tbl%0d_rvalid", i), 32'(s_rvalid), 32'(tbl[i].e_rvalid));
         if (tbl[i].chk_rdata)
            chk($sformatf("tbl%0d_cpu_rdata", i), s_cpu_rdata, tbl[i].e_rdata);
      end

      // Reset arriving on the cycle a DMA write would be forced in
      pre = mem[32];
      for (int k = 0; k < MAX_WAIT; k++) begin
         apply(1'b0, 1'b1, 1'b0, 32'h4000_0004, 32'h0, 1'b1, 1'b1, 32'h0000_0080, 32'hCAFE_F00D);
         chk("starve_wr_refused", 32'(s_gnt), 32'h0);
      end
      apply(1'b1, 1'b1, 1'b0, 32'h4000_0004, 32'h0, 1'b1, 1'b1, 32'h0000_0080, 32'hCAFE_F00D);
      chk("rst_force_bus_wr", 32'(s_wr), 32'h0);
      chk("rst_mem_kept", mem[32], pre);
      idle_cycle();
      chk("rst_rvalid_clear", 32'(s_rvalid), 32'h0);
      apply(1'b0, 1'b1, 1'b0, 32'h0000_0080, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("rst_mem_readback", s_cpu_rdata, pre);

      // Random traffic; the DMA holds its request until granted
      d_pend = 1'b0; d_we_r = 1'b0; d_addr_r = '0; d_wdata_r = '0;
      for (int i = 0; i < 400; i++) begin
         if (!d_pend && $urandom_range(0, 2) == 0) begin
            d_pend    = 1'b1;
            d_we_r    = 1'($urandom_range(0, 1));
            d_addr_r  = $urandom & 32'h4000_03FC;
            d_wdata_r = $urandom;
         end
         op  = $urandom_range(0, 7);
         crd = (op <= 2) || (op == 5);
         cwr = (op == 3) || (op == 4) || (op == 5);
         rr  = ($urandom_range(0, 99) == 0);
         apply(rr, crd, cwr, $urandom & 32'h4000_03FC, $urandom,
               d_pend, d_we_r, d_addr_r, d_wdata_r);
         if (s_gnt || rr) d_pend = 1'b0;
      end

`ifdef ARB_PERF_CNT_EN
      apply(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k <= MAX_WAIT; k++)
            apply(1'b0, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 1'b1, 1'b0, 32'h0000_0020, 32'h0);
      end
      idle_cycle();
      chk("perf_force_cnt", 32'(perf_force_cnt), 32'd3);
      chk("perf_stall_cnt", 32'(perf_stall_cnt), 32'd3);
      chk("perf_force_model", 32'(perf_force_cnt), 32'(m_force_cnt));
      chk("perf_stall_model", 32'(perf_stall_cnt), 32'(m_stall_cnt));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
